// File: rtl/knn_dist_sequencer_pkg.sv
// Shared types and constants for the KNN distance sequencer: entry layout,
// coordinate/distance widths and the squared-delta helper.
package knn_dist_sequencer_pkg;

  localparam int BIT_WIDTH  = 16;
  localparam int K_DEFAULT  = 8;
  localparam int ID_W       = 16;
  localparam int SQ_W       = 2 * (BIT_WIDTH + 1);
  localparam int DIST_WIDTH = 2 * BIT_WIDTH + 3;

  localparam logic [DIST_WIDTH-1:0] DIST_INVALID = '1;

  typedef struct packed {
    logic signed [BIT_WIDTH-1:0] x;
    logic signed [BIT_WIDTH-1:0] y;
    logic signed [BIT_WIDTH-1:0] z;
    logic [ID_W-1:0]             point_id;
    logic                        valid;
    logic [DIST_WIDTH-1:0]       distance;
  } knn_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } seq_state_e;

  // Delta is widened by one bit first so that full-scale opposite corners
  // cannot overflow; the square of a signed value is always non-negative.
  function automatic logic [SQ_W-1:0] sq_delta(input logic signed [BIT_WIDTH-1:0] c,
                                               input logic signed [BIT_WIDTH-1:0] q);
    logic signed [BIT_WIDTH:0] d;
    logic signed [SQ_W-1:0]    de;
    d  = (BIT_WIDTH + 1)'(c) - (BIT_WIDTH + 1)'(q);
    de = SQ_W'(d);
    return $unsigned(de * de);
  endfunction

endpackage

// File: rtl/knn_dist_sequencer_if.sv
// Query/snapshot input handshake and completed-entry output stream of the
// KNN distance sequencer.
interface knn_dist_sequencer_if
  import knn_dist_sequencer_pkg::*;
#(
  parameter int K = K_DEFAULT
) ();

  localparam int IDX_W = $clog2(K);

  logic                        start_valid;
  logic                        start_ready;
  logic signed [BIT_WIDTH-1:0] qp_x;
  logic signed [BIT_WIDTH-1:0] qp_y;
  logic signed [BIT_WIDTH-1:0] qp_z;
  knn_entry_t                  cand_in [K];
  logic                        out_valid;
  logic                        out_ready;
  knn_entry_t                  out_entry;
  logic [IDX_W-1:0]            out_index;
  logic                        out_last;
  logic                        busy;
  logic                        done;

  modport master (
    output start_valid, qp_x, qp_y, qp_z, cand_in, out_ready,
    input  start_ready, out_valid, out_entry, out_index, out_last, busy, done
  );

  modport slave (
    input  start_valid, qp_x, qp_y, qp_z, cand_in, out_ready,
    output start_ready, out_valid, out_entry, out_index, out_last, busy, done
  );

endinterface

// File: rtl/knn_dist_sequencer_sq_dist.sv
// Two-stage squared-Euclidean distance unit with a shared stall enable;
// the entry and a sideband tag travel alongside the arithmetic.
module knn_sq_dist
  import knn_dist_sequencer_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic                        vld_i,
  input  knn_entry_t                  ent_i,
  input  logic signed [BIT_WIDTH-1:0] qx_i,
  input  logic signed [BIT_WIDTH-1:0] qy_i,
  input  logic signed [BIT_WIDTH-1:0] qz_i,
  input  logic [TAG_W-1:0]            tag_i,
  output logic                        vld_o,
  output knn_entry_t                  ent_o,
  output logic [TAG_W-1:0]            tag_o
);

  // Invalid slots still flow through so indices stay contiguous, but carry
  // a distance that sorts them to the far end.
  function automatic logic [DIST_WIDTH-1:0] dist_sel(input logic                  v,
                                                     input logic [DIST_WIDTH-1:0] d);
    return v ? d : DIST_INVALID;
  endfunction

  logic [SQ_W-1:0]       sqx_p1_q, sqy_p1_q, sqz_p1_q;
  knn_entry_t            ent_p1_q;
  logic [TAG_W-1:0]      tag_p1_q;
  logic                  vld_p1_q;
  logic [DIST_WIDTH-1:0] sum_p1;
  knn_entry_t            ent_p2_d;
  knn_entry_t            ent_p2_q;
  logic [TAG_W-1:0]      tag_p2_q;
  logic                  vld_p2_q;

  // ---- stage 1: squares ----
  always_ff @(posedge clk) begin
    if (en_i) begin
      sqx_p1_q <= sq_delta(ent_i.x, qx_i);
      sqy_p1_q <= sq_delta(ent_i.y, qy_i);
      sqz_p1_q <= sq_delta(ent_i.z, qz_i);
      ent_p1_q <= ent_i;
      tag_p1_q <= tag_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    vld_p1_q <= 1'b0;
    else if (en_i) vld_p1_q <= vld_i;
  end

  always_comb begin
    sum_p1            = DIST_WIDTH'(sqx_p1_q) + DIST_WIDTH'(sqy_p1_q) + DIST_WIDTH'(sqz_p1_q);
    ent_p2_d          = ent_p1_q;
    ent_p2_d.distance = dist_sel(ent_p1_q.valid, sum_p1);
  end

  // ---- stage 2: sum, drives the output stream directly ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      ent_p2_q <= '0;
      tag_p2_q <= '0;
    end else if (en_i) begin
      vld_p2_q <= vld_p1_q;
      ent_p2_q <= ent_p2_d;
      tag_p2_q <= tag_p1_q;
    end
  end

  assign vld_o = vld_p2_q;
  assign ent_o = ent_p2_q;
  assign tag_o = tag_p2_q;

endmodule

// File: rtl/knn_dist_sequencer.sv
// Streams a K-entry candidate snapshot through one shared distance unit and
// emits each entry, distance filled in, on a valid/ready stream.
module knn_dist_sequencer
  import knn_dist_sequencer_pkg::*;
#(
  parameter int K        = K_DEFAULT,
  parameter int DIST_LAT = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  knn_dist_sequencer_if.slave  bus
);

  localparam int                IDX_W    = $clog2(K);
  localparam int                TAG_W    = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  if (K < 2 || DIST_LAT != 2) begin : g_bad_cfg
    $error("knn_dist_sequencer: K must be >= 2 and DIST_LAT must be 2");
  end

  seq_state_e                  state_q, state_d;
  logic [IDX_W-1:0]            cnt_q, cnt_d;
  logic                        done_q, done_d;
  logic                        accept;
  logic                        en;
  knn_entry_t                  snap_q [K];
  logic signed [BIT_WIDTH-1:0] qx_q, qy_q, qz_q;
  logic [TAG_W-1:0]            tag_p0;
  logic                        vld_o;
  knn_entry_t                  ent_o;
  logic [TAG_W-1:0]            tag_o;

  // Everything advances together unless the held output is being refused.
  assign en = !(vld_o && !bus.out_ready);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (en) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (vld_o && bus.out_ready && tag_o[IDX_W]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // ---- snapshot capture on accept ----
  always_ff @(posedge clock) begin
    if (accept) begin
      snap_q <= bus.cand_in;
      qx_q   <= bus.qp_x;
      qy_q   <= bus.qp_y;
      qz_q   <= bus.qp_z;
    end
  end

  assign tag_p0 = {cnt_q == LAST_IDX, cnt_q};

  knn_sq_dist #(
    .TAG_W (TAG_W)
  ) u_sq_dist (
    .clk   (clock),
    .rst_n (reset_n),
    .en_i  (en),
    .vld_i (state_q == ST_ISSUE),
    .ent_i (snap_q[cnt_q]),
    .qx_i  (qx_q),
    .qy_i  (qy_q),
    .qz_i  (qz_q),
    .tag_i (tag_p0),
    .vld_o (vld_o),
    .ent_o (ent_o),
    .tag_o (tag_o)
  );

  assign bus.out_valid   = vld_o;
  assign bus.out_entry   = ent_o;
  assign bus.out_index   = tag_o[IDX_W-1:0];
  assign bus.out_last    = tag_o[IDX_W];
  assign bus.done        = done_q;
  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_knn_dist_sequencer.sv
// Directed bench for knn_dist_sequencer with K=4 and hand-computed distances.
module tb_knn_dist_sequencer;
  import knn_dist_sequencer_pkg::*;

  localparam int KT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  knn_dist_sequencer_if #(.K(KT)) bus ();

  knn_dist_sequencer #(.K(KT), .DIST_LAT(2)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic                  cap_v    [32];
  logic                  cap_last [32];
  logic                  cap_done [32];
  logic                  cap_sr   [32];
  logic                  cap_ev   [32];
  logic [1:0]            cap_idx  [32];
  logic [DIST_WIDTH-1:0] cap_dist [32];
  logic [ID_W-1:0]       cap_id   [32];

  knn_entry_t set_a [KT];
  knn_entry_t set_b [KT];

  function automatic knn_entry_t mk(input logic [15:0] x, input logic [15:0] y,
                                    input logic [15:0] z, input logic [15:0] id,
                                    input logic v);
    knn_entry_t e;
    e          = '0;
    e.x        = x;
    e.y        = y;
    e.z        = z;
    e.point_id = id;
    e.valid    = v;
    return e;
  endfunction

  task automatic load_query(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    bus.qp_x = x;
    bus.qp_y = y;
    bus.qp_z = z;
  endtask

  // Caller has start_valid high at a negedge (cycle 0). Samples cycles 1..nc.
  task automatic capture(input int nc, input logic [31:0] stall, input logic hold_start,
                         input logic swap_b);
    @(posedge clk);
    for (int c = 1; c <= nc; c++) begin
      @(negedge clk);
      if (!hold_start || c == nc) bus.start_valid = 1'b0;
      cap_v[c]    = bus.out_valid;
      cap_idx[c]  = bus.out_index;
      cap_last[c] = bus.out_last;
      cap_dist[c] = bus.out_entry.distance;
      cap_ev[c]   = bus.out_entry.valid;
      cap_id[c]   = bus.out_entry.point_id;
      cap_done[c] = bus.done;
      cap_sr[c]   = bus.start_ready;
      bus.out_ready = !stall[c];
      if (swap_b && c == 1) begin
        bus.cand_in = set_b;
        load_query(16'd1, 16'd1, 16'd1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_valid = 1'b0;
    bus.out_ready   = 1'b1;
    load_query(16'd0, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready got %b want 1", bus.start_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.out_last !== 1'b0 || bus.out_index !== 2'd0) begin
      n_fail++; $display("FAIL reset_last_index got %b/%0d want 0/0", bus.out_last, bus.out_index); end
    n_cmp++; if (bus.out_entry !== '0) begin n_fail++; $display("FAIL reset_entry got %h want 0", bus.out_entry); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [DIST_WIDTH-1:0] ed [4];
    logic ev;
    ed[0] = 35'd25; ed[1] = 35'd25; ed[2] = 35'd3; ed[3] = 35'd0;
    @(negedge clk);
    bus.cand_in = set_a;
    load_query(16'd0, 16'd0, 16'd0);
    bus.out_ready   = 1'b1;
    bus.start_valid = 1'b1;
    capture(8, 32'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      ev = (c >= 3 && c <= 6);
      n_cmp++; if (cap_v[c] !== ev) begin n_fail++; $display("FAIL basic_valid c%0d got %b want %b", c, cap_v[c], ev); end
      n_cmp++; if (cap_done[c] !== (c == 7)) begin n_fail++; $display("FAIL basic_done c%0d got %b want %b", c, cap_done[c], c == 7); end
      n_cmp++; if (cap_sr[c] !== (c >= 7)) begin n_fail++; $display("FAIL basic_start_ready c%0d got %b want %b", c, cap_sr[c], c >= 7); end
      if (ev) begin
        n_cmp++; if (cap_idx[c] !== 2'(c - 3)) begin n_fail++; $display("FAIL basic_index c%0d got %0d want %0d", c, cap_idx[c], c - 3); end
        n_cmp++; if (cap_dist[c] !== ed[c-3]) begin n_fail++; $display("FAIL basic_dist c%0d got %0d want %0d", c, cap_dist[c], ed[c-3]); end
        n_cmp++; if (cap_last[c] !== (c == 6)) begin n_fail++; $display("FAIL basic_last c%0d got %b want %b", c, cap_last[c], c == 6); end
        n_cmp++; if (cap_id[c] !== 16'(10 + c - 3) || cap_ev[c] !== 1'b1) begin
          n_fail++; $display("FAIL basic_passthru c%0d got id %0d v %b want id %0d v 1", c, cap_id[c], cap_ev[c], 10 + c - 3); end
      end
    end
  endtask

  task automatic test_extreme();
    logic [DIST_WIDTH-1:0] ed [4];
    ed[0] = 35'd12884508675; ed[1] = 35'd3221225472; ed[2] = 35'd0; ed[3] = 35'd5368578049;
    @(negedge clk);
    bus.cand_in[0] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd20, 1'b1);
    bus.cand_in[1] = mk(16'h0000, 16'h0000, 16'h0000, 16'd21, 1'b1);
    bus.cand_in[2] = mk(16'h8000, 16'h8000, 16'h8000, 16'd22, 1'b1);
    bus.cand_in[3] = mk(16'h7FFF, 16'h8000, 16'h0000, 16'd23, 1'b1);
    load_query(16'h8000, 16'h8000, 16'h8000);
    bus.start_valid = 1'b1;
    capture(8, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cap_v[3+i] !== 1'b1 || cap_dist[3+i] !== ed[i]) begin
        n_fail++; $display("FAIL extreme_dist i%0d got v%b %0d want v1 %0d", i, cap_v[3+i], cap_dist[3+i], ed[i]); end
    end
    n_cmp++; if (cap_done[7] !== 1'b1) begin n_fail++; $display("FAIL extreme_done got %b want 1", cap_done[7]); end
  endtask

  task automatic test_stall();
    logic [DIST_WIDTH-1:0] ed [4];
    int                    ei [13];
    ed[0] = 35'd25; ed[1] = 35'd25; ed[2] = 35'd3; ed[3] = 35'd0;
    // expected index per cycle, -1 when out_valid must be low
    ei = '{-1, -1, -1, 0, 1, 1, 1, 1, 2, 3, -1, -1, -1};
    @(negedge clk);
    bus.cand_in = set_a;
    load_query(16'd0, 16'd0, 16'd0);
    bus.start_valid = 1'b1;
    capture(11, 32'h0000_0070, 1'b0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      n_cmp++; if (cap_v[c] !== (ei[c] >= 0)) begin n_fail++; $display("FAIL stall_valid c%0d got %b want %b", c, cap_v[c], ei[c] >= 0); end
      if (ei[c] >= 0) begin
        n_cmp++; if (cap_idx[c] !== 2'(ei[c]) || cap_dist[c] !== ed[ei[c]]) begin
          n_fail++; $display("FAIL stall_entry c%0d got idx %0d d %0d want idx %0d d %0d", c, cap_idx[c], cap_dist[c], ei[c], ed[ei[c]]); end
        n_cmp++; if (cap_last[c] !== (ei[c] == 3)) begin n_fail++; $display("FAIL stall_last c%0d got %b want %b", c, cap_last[c], ei[c] == 3); end
      end
      n_cmp++; if (cap_done[c] !== (c == 10)) begin n_fail++; $display("FAIL stall_done c%0d got %b want %b", c, cap_done[c], c == 10); end
    end
  endtask

  task automatic test_invalid();
    logic [DIST_WIDTH-1:0] ed [4];
    ed[0] = 35'd25; ed[1] = 35'd25; ed[2] = DIST_INVALID; ed[3] = 35'd0;
    @(negedge clk);
    bus.cand_in    = set_a;
    bus.cand_in[2] = mk(16'd1, 16'd1, 16'd1, 16'd12, 1'b0);
    load_query(16'd0, 16'd0, 16'd0);
    bus.start_valid = 1'b1;
    capture(8, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cap_v[3+i] !== 1'b1 || cap_idx[3+i] !== 2'(i)) begin
        n_fail++; $display("FAIL invalid_seq i%0d got v%b idx %0d want v1 idx %0d", i, cap_v[3+i], cap_idx[3+i], i); end
      n_cmp++; if (cap_dist[3+i] !== ed[i] || cap_ev[3+i] !== (i != 2)) begin
        n_fail++; $display("FAIL invalid_entry i%0d got d %0d v %b want d %0d v %b", i, cap_dist[3+i], cap_ev[3+i], ed[i], i != 2); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cand_in = set_a;
    load_query(16'd0, 16'd0, 16'd0);
    bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got %b want 1", bus.out_valid); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_state got sr %b busy %b want sr 1 busy 0", bus.start_ready, bus.busy); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
        n_fail++; $display("FAIL rstmid_quiet c%0d got done %b ov %b sr %b want 0 0 1", c, bus.done, bus.out_valid, bus.start_ready); end
    end
    bus.start_valid = 1'b1;
    capture(8, 32'd0, 1'b0, 1'b0);
    n_cmp++; if (cap_v[3] !== 1'b1 || cap_dist[3] !== 35'd25 || cap_idx[3] !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_rerun_first got v%b d %0d idx %0d want v1 d 25 idx 0", cap_v[3], cap_dist[3], cap_idx[3]); end
    n_cmp++; if (cap_done[7] !== 1'b1 || cap_done[6] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_rerun_done got c6 %b c7 %b want 0 1", cap_done[6], cap_done[7]); end
  endtask

  task automatic test_back_to_back();
    logic [DIST_WIDTH-1:0] ea [4];
    logic [DIST_WIDTH-1:0] eb [4];
    logic ev;
    ea[0] = 35'd25; ea[1] = 35'd25; ea[2] = 35'd3; ea[3] = 35'd0;
    eb[0] = 35'd0;  eb[1] = 35'd14; eb[2] = 35'd4; eb[3] = 35'd100;
    @(negedge clk);
    bus.cand_in = set_a;
    load_query(16'd0, 16'd0, 16'd0);
    bus.start_valid = 1'b1;
    capture(14, 32'd0, 1'b1, 1'b1);
    for (int c = 1; c <= 14; c++) begin
      ev = (c >= 3 && c <= 6) || (c >= 10 && c <= 13);
      n_cmp++; if (cap_v[c] !== ev) begin n_fail++; $display("FAIL b2b_valid c%0d got %b want %b", c, cap_v[c], ev); end
      n_cmp++; if (cap_done[c] !== (c == 7 || c == 14)) begin n_fail++; $display("FAIL b2b_done c%0d got %b want %b", c, cap_done[c], c == 7 || c == 14); end
      n_cmp++; if (cap_sr[c] !== (c == 7 || c == 14)) begin n_fail++; $display("FAIL b2b_start_ready c%0d got %b want %b", c, cap_sr[c], c == 7 || c == 14); end
      if (c >= 3 && c <= 6) begin
        n_cmp++; if (cap_dist[c] !== ea[c-3] || cap_idx[c] !== 2'(c - 3)) begin
          n_fail++; $display("FAIL b2b_first c%0d got d %0d idx %0d want d %0d idx %0d", c, cap_dist[c], cap_idx[c], ea[c-3], c - 3); end
      end
      if (c >= 10 && c <= 13) begin
        n_cmp++; if (cap_dist[c] !== eb[c-10] || cap_idx[c] !== 2'(c - 10) || cap_last[c] !== (c == 13)) begin
          n_fail++; $display("FAIL b2b_second c%0d got d %0d idx %0d last %b want d %0d idx %0d last %b",
                             c, cap_dist[c], cap_idx[c], cap_last[c], eb[c-10], c - 10, c == 13); end
      end
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_idle got busy %b want 0", bus.busy); end
  endtask

  initial begin
    set_a[0] = mk(16'd3, 16'd4, 16'd0, 16'd10, 1'b1);
    set_a[1] = mk(-16'sd3, -16'sd4, 16'd0, 16'd11, 1'b1);
    set_a[2] = mk(16'd1, 16'd1, 16'd1, 16'd12, 1'b1);
    set_a[3] = mk(16'd0, 16'd0, 16'd0, 16'd13, 1'b1);
    set_b[0] = mk(16'd1, 16'd1, 16'd1, 16'd30, 1'b1);
    set_b[1] = mk(16'd2, 16'd3, 16'd4, 16'd31, 1'b1);
    set_b[2] = mk(-16'sd1, 16'd1, 16'd1, 16'd32, 1'b1);
    set_b[3] = mk(16'd1, 16'd1, -16'sd9, 16'd33, 1'b1);
    bus.cand_in = set_a;

    test_reset();
    test_basic();
    test_extreme();
    test_stall();
    test_invalid();
    test_reset_mid();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/knn_dist_sequencer.md
# knn_dist_sequencer

Sequences one query through the K-entry previous-KNN list: accepts a query point plus a K-entry candidate snapshot, streams the entries one per cycle through a pipelined squared-distance unit, and emits each entry with its distance filled in on a valid/ready output stream. Sits between the query front end and the KNN sort/merge stage. It time-multiplexes one distance unit instead of K parallel copies.

## Interface
- `K`, default `` `K `` (8 in the package), number of candidate entries per query; must be ≥2.
- `DIST_LAT`, default 2, register stages in the distance unit; fixed at 2 in this revision.
- `clock`  in  1  rising-edge clock for all state.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  query and snapshot presented.
- `start_ready`  out  1  sequencer idle and able to accept.
- `qp_x`, `qp_y`, `qp_z`  in  `` `BIT_WIDTH `` each  query coordinates, signed two's complement.
- `cand_in`  in  K × knn_entry_t  candidate snapshot, sampled on accept.
- `out_valid`  out  1  `out_entry` holds a completed entry.
- `out_ready`  in  1  downstream accepts `out_entry`.
- `out_entry`  out  knn_entry_t  candidate with `distance` filled in; other fields pass through.
- `out_index`  out  $clog2(K)  slot index of `out_entry`, 0..K-1.
- `out_last`  out  1  high with index K-1.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last output transfer.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: `start_ready`=1. On `start_valid && start_ready`, register qp_x/y/z and all K entries of `cand_in`, clear the issue counter, and go to ISSUE.
- ISSUE: each unstalled cycle, issue snapshot entry [counter] into the distance unit and increment the counter. After issuing index K-1, go to DRAIN.
- DRAIN: wait until the final entry completes its transfer (`out_valid && out_ready && out_last`), then go to IDLE and pulse `done`.
- Distance: d = dx² + dy² + dz², where each delta is the candidate coordinate minus the query coordinate.
  - Deltas are computed sign-extended to `` `BIT_WIDTH ``+1 bits.
  - Squares are 2·(`` `BIT_WIDTH ``+1) bits, unsigned.
  - The sum is `DIST_WIDTH` = 2·`` `BIT_WIDTH ``+3 bits. The sum never wraps or saturates.
- Entries with `valid`=0 are still issued and emitted so that the index sequence is contiguous. Their `distance` is forced to all-ones and their `valid` stays 0.
- Stall: when `out_valid && !out_ready`, the issue counter, every pipeline stage, and the output register all hold. `out_entry`, `out_index` and `out_last` stay stable. No entry is dropped or duplicated, and no bubble is inserted when the stall releases.
- `start_valid` is ignored outside IDLE.
- Changes to `cand_in` or `qp_*` after the accept have no effect on the current query.
- Reset value of every output: 0, except `start_ready`=1. The FSM resets to IDLE, the pipeline valid bits clear, and the counter clears.
- Reset asserted mid-query discards the query. `out_valid` drops asynchronously and no `done` is produced.

## Timing
- Cycle 0: accept edge. Cycle 1: index 0 is issued.
- Without stalls, index i is presented on `out_*` in cycle 1+i+DIST_LAT. The first output appears in cycle 3; the last appears in cycle K+2.
- `done`=1 and `start_ready`=1 in cycle K+3 with `out_ready` held high. `done` is asserted in the same cycle the FSM enters IDLE.
- A new query can be accepted in the cycle `done` is high. Back-to-back throughput is one query per K+3 cycles.
- Each stall cycle extends completion by exactly one cycle.
- `out_*` are driven directly from registers, with no combinational path from `out_ready`. `start_ready` is decoded from state only.

## Structure
- The shared package holds:
  - the `knn_entry_t` struct (x, y, z, point_id, valid, distance);
  - `` `BIT_WIDTH `` and `` `K ``;
  - `DIST_WIDTH`;
  - the `DIST_INVALID` all-ones constant.
- Sub-module `knn_sq_dist`:
  - 2-stage pipeline. Stage 1 registers the three squares; stage 2 registers the sum and the pass-through fields.
  - Inputs: `en` (the stall control) and valid.
- Sequencer FSM, counter, snapshot registers and output mux stay in the top level.

## Test plan
- `BIT_WIDTH`=16, K=4, query (0,0,0), candidates (3,4,0), (-3,-4,0), (1,1,1), (0,0,0), `out_ready`=1 → distances 25, 25, 3, 0 at indices 0..3 in cycles 3..6, `out_last` only on index 3, `done` in cycle 7.
- Query (-32768,-32768,-32768), candidate (32767,32767,32767) → distance 12884508675 with no overflow in the 35-bit field.
- Same stream as the first test with `out_ready` low in cycles 4–6 → index 1 held stable for 3 cycles, order 0..3 preserved, `done` in cycle 10.
- Candidate 2 with `valid`=0 → emitted at index 2 with distance all-ones and `valid`=0; the other entries are unaffected.
- `reset_n` pulsed low in cycle 4 → `out_valid`=0 immediately, no `done`, `start_ready`=1 after release, and the next query runs normally.
- `start_valid` held high continuously → second query accepted in the `done` cycle, its first output in that cycle+3; `start_valid` during busy is ignored.
